// File: rtl/minesweeper_pkg.sv
// minesweeper_pkg: shared state encoding and cell indexing for the minesweeper controller
package minesweeper_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PLAY  = 3'd2,
    CHECK = 3'd3,
    LOSE  = 3'd4,
    WIN   = 3'd5
  } ms_state_e;
  function automatic int cell_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction
endpackage

// File: rtl/ms_cursor.sv
// ms_cursor: board cursor with wrap-around moves, priority up > down > left > right
module ms_cursor #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  input  logic          enable,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o
);
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (enable) begin
      if (up) row_d = (row_q == '0) ? RW'(ROWS - 1) : row_q - 1'b1;
      else if (down) row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
      else if (left) col_d = (col_q == '0) ? CW'(COLS - 1) : col_q - 1'b1;
      else if (right) col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end
  assign row_o = row_q;
  assign col_o = col_q;
endmodule

// File: rtl/minesweeper_ctrl.sv
// minesweeper_ctrl: game FSM, revealed/flagged bitmaps, flag budget and safe-reveal counter
module minesweeper_ctrl
  import minesweeper_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int MINES = 10,
  localparam int N  = ROWS * COLS,
  localparam int RW = $clog2(ROWS),
  localparam int CW = $clog2(COLS),
  localparam int FW = $clog2(MINES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  mine_map,
  input  logic          up,
  input  logic          down,
  input  logic          left,
  input  logic          right,
  input  logic          reveal,
  input  logic          flag,
  output logic [RW-1:0] cur_row,
  output logic [CW-1:0] cur_col,
  output logic [N-1:0]  revealed,
  output logic [N-1:0]  flagged,
  output logic [FW-1:0] flags_left,
  output logic [2:0]    state_o,
  output logic          playing,
  output logic          game_over,
  output logic          win
);
  localparam int IW = $clog2(N);
  localparam int NW = $clog2(N + 1);
  ms_state_e     state_q, state_d;
  logic [N-1:0]  map_q, map_d, rev_q, rev_d, flg_q, flg_d;
  logic [FW-1:0] fl_q, fl_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx;
  logic          hit, tog, go;
  assign idx = IW'(cell_idx(int'(cur_row), int'(cur_col), COLS));
  assign go  = start && (state_q == IDLE || state_q == LOSE || state_q == WIN);
  assign hit = state_q == PLAY && reveal && !rev_q[idx] && !flg_q[idx];
  assign tog = state_q == PLAY && !reveal && flag && !rev_q[idx] && (flg_q[idx] || fl_q != '0);
  ms_cursor #(.ROWS(ROWS), .COLS(COLS)) u_cursor (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == LOAD),
    .up     (up),
    .down   (down),
    .left   (left),
    .right  (right),
    .enable (state_q == PLAY && !reveal && !flag),
    .row_o  (cur_row),
    .col_o  (cur_col)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, LOSE, WIN: state_d = go ? LOAD : state_q;
      LOAD:            state_d = PLAY;
      PLAY:            state_d = hit ? (map_q[idx] ? LOSE : CHECK) : PLAY;
      CHECK:           state_d = (cnt_q == NW'(N - MINES)) ? WIN : PLAY;
      default:         state_d = IDLE;
    endcase
  end
  always_comb begin
    state_o   = state_q;
    playing   = state_q == PLAY;
    game_over = state_q == LOSE;
    win       = state_q == WIN;
  end
  // Mines are exposed on the same edge that takes us into LOSE.
  always_comb begin
    map_d = go ? mine_map : map_q;
    rev_d = rev_q;
    flg_d = flg_q;
    fl_d  = fl_q;
    cnt_d = cnt_q;
    if (state_q == LOAD) begin
      rev_d = '0;
      flg_d = '0;
      fl_d  = FW'(MINES);
      cnt_d = '0;
    end
    if (hit) begin
      rev_d[idx] = 1'b1;
      if (map_q[idx]) rev_d = rev_d | map_q;
      else cnt_d = cnt_q + 1'b1;
    end
    if (tog) begin
      flg_d[idx] = !flg_q[idx];
      fl_d = flg_q[idx] ? fl_q + 1'b1 : fl_q - 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_q <= '0;
      rev_q <= '0;
      flg_q <= '0;
      fl_q  <= FW'(MINES);
      cnt_q <= '0;
    end else begin
      map_q <= map_d;
      rev_q <= rev_d;
      flg_q <= flg_d;
      fl_q  <= fl_d;
      cnt_q <= cnt_d;
    end
  end
  assign revealed   = rev_q;
  assign flagged    = flg_q;
  assign flags_left = fl_q;
endmodule

// File: tb/tb_minesweeper_ctrl.sv
// tb_minesweeper_ctrl: directed scoreboard bench on two 4x4 boards (MINES=1 and MINES=2)
module tb_minesweeper_ctrl;
  localparam logic [6:0] P_ST = 7'b1000000, P_UP = 7'b0100000, P_DN = 7'b0010000,
                         P_LF = 7'b0001000, P_RT = 7'b0000100, P_RV = 7'b0000010,
                         P_FL = 7'b0000001;
  logic clk = 0, rst = 1;
  logic start = 0, up = 0, down = 0, left = 0, right = 0, reveal = 0, flag = 0;
  logic [15:0] mine_map = 16'h0001;
  logic [1:0] a_row, a_col, b_row, b_col;
  logic [15:0] a_rev, a_flg, b_rev, b_flg;
  logic a_fl;
  logic [1:0] b_fl;
  logic [2:0] a_st, b_st;
  logic a_play, a_over, a_win, b_play, b_over, b_win;
  int n_chk = 0, n_fail = 0, mr = 0, mc = 0, k = 0;
  logic [31:0] exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  minesweeper_ctrl #(.ROWS(4), .COLS(4), .MINES(1)) u_a (
    .clk(clk), .rst(rst), .start(start), .mine_map(mine_map), .up(up), .down(down),
    .left(left), .right(right), .reveal(reveal), .flag(flag), .cur_row(a_row),
    .cur_col(a_col), .revealed(a_rev), .flagged(a_flg), .flags_left(a_fl),
    .state_o(a_st), .playing(a_play), .game_over(a_over), .win(a_win));
  minesweeper_ctrl #(.ROWS(4), .COLS(4), .MINES(2)) u_b (
    .clk(clk), .rst(rst), .start(start), .mine_map(mine_map), .up(up), .down(down),
    .left(left), .right(right), .reveal(reveal), .flag(flag), .cur_row(b_row),
    .cur_col(b_col), .revealed(b_rev), .flagged(b_flg), .flags_left(b_fl),
    .state_o(b_st), .playing(b_play), .game_over(b_over), .win(b_win));

  task automatic exp_v(input string t, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask
  task automatic chk(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_chk++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", t, obs, e);
    end
  endtask
  task automatic cyc(input logic [6:0] p);
    @(negedge clk);
    {start, up, down, left, right, reveal, flag} = p;
    @(negedge clk);
    {start, up, down, left, right, reveal, flag} = '0;
  endtask
  task automatic goto(input int r, input int c);
    while (mr != r) begin cyc(P_DN); mr = (mr + 1) % 4; end
    while (mc != c) begin cyc(P_RT); mc = (mc + 1) % 4; end
  endtask

  initial begin
    exp_v("rst_state", 0); exp_v("rst_flags", 1); exp_v("rst_rev", 0);
    exp_v("rst_row", 0); exp_v("rst_play", 0);
    repeat (2) @(negedge clk);
    chk(32'(a_st)); chk(32'(a_fl)); chk(32'(a_rev)); chk(32'(a_row)); chk(32'(a_play));
    rst = 0;
    exp_v("load", 1); cyc(P_ST); chk(32'(a_st));
    exp_v("play", 2); exp_v("playing", 1); exp_v("load_flags", 1);
    cyc(0); chk(32'(a_st)); chk(32'(a_play)); chk(32'(a_fl));
    exp_v("start_in_play", 2); cyc(P_ST); chk(32'(a_st));
    cyc(P_RT); mc = 1;
    cyc(P_UP); mr = 3;
    exp_v("wrap_row", 3); exp_v("col1", 1); chk(32'(a_row)); chk(32'(a_col));
    cyc(P_LF); cyc(P_LF); mc = 3;
    exp_v("wrap_col", 3); chk(32'(a_col));
    exp_v("rv_rt_state", 3); exp_v("rv_rt_col", 3); exp_v("rv_rt_rev", 32'h8000);
    cyc(P_RV | P_RT); chk(32'(a_st)); chk(32'(a_col)); chk(32'(a_rev));
    exp_v("back_play", 2); cyc(0); chk(32'(a_st));
    exp_v("rerev_state", 2); exp_v("rerev_rev", 32'h8000);
    cyc(P_RV); chk(32'(a_st)); chk(32'(a_rev));
    k = 1;
    for (int i = 1; i < 15; i++) begin
      goto(i / 4, i % 4);
      k++;
      exp_v("reveal_check", 3); cyc(P_RV); chk(32'(a_st));
      exp_v("after_check", k == 15 ? 5 : 2); cyc(0); chk(32'(a_st));
    end
    exp_v("end_row", 3); exp_v("end_col", 2); exp_v("win", 1); exp_v("win_rev", 32'hFFFE);
    exp_v("win_over", 0);
    chk(32'(a_row)); chk(32'(a_col)); chk(32'(a_win)); chk(32'(a_rev)); chk(32'(a_over));
    exp_v("win_restart", 1); cyc(P_ST); chk(32'(a_st));
    mr = 0; mc = 0;
    exp_v("g2_play", 2); exp_v("g2_rev", 0); exp_v("g2_row", 0); exp_v("g2_col", 0);
    cyc(0); chk(32'(a_st)); chk(32'(a_rev)); chk(32'(a_row)); chk(32'(a_col));
    exp_v("lose_state", 4); exp_v("lose_over", 1); exp_v("lose_rev", 32'h0001);
    cyc(P_RV); chk(32'(a_st)); chk(32'(a_over)); chk(32'(a_rev));
    exp_v("lose_ignore", 4); cyc(P_RT); chk(32'(a_st));
    exp_v("lose_restart", 1); cyc(P_ST); chk(32'(a_st));
    exp_v("g3_play", 2); exp_v("g3_rev", 0); exp_v("g3_flg", 0);
    cyc(0); chk(32'(a_st)); chk(32'(a_rev)); chk(32'(a_flg));
    cyc(P_RT);
    exp_v("pre_rst_flg", 32'h0002); exp_v("pre_rst_fl", 0);
    cyc(P_FL); chk(32'(a_flg)); chk(32'(a_fl));
    @(negedge clk);
    #2 rst = 1;
    exp_v("arst_state", 0); exp_v("arst_col", 0); exp_v("arst_flg", 0);
    exp_v("arst_fl", 1); exp_v("arst_play", 0);
    #1 chk(32'(a_st)); chk(32'(a_col)); chk(32'(a_flg)); chk(32'(a_fl)); chk(32'(a_play));
    @(negedge clk);
    rst = 0;
    mine_map = 16'h0021;
    exp_v("b_load", 1); cyc(P_ST); chk(32'(b_st));
    exp_v("b_play", 2); exp_v("b_fl2", 2); cyc(0); chk(32'(b_st)); chk(32'(b_fl));
    exp_v("b_fl1", 1); cyc(P_FL); chk(32'(b_fl));
    cyc(P_RT);
    exp_v("b_fl0", 0); cyc(P_FL); chk(32'(b_fl));
    cyc(P_RT);
    exp_v("b_third_fl", 0); exp_v("b_third_flg", 32'h0003);
    cyc(P_FL); chk(32'(b_fl)); chk(32'(b_flg));
    cyc(P_LF);
    exp_v("b_unflag_fl", 1); exp_v("b_unflag_flg", 32'h0001);
    cyc(P_FL); chk(32'(b_fl)); chk(32'(b_flg));
    cyc(P_LF);
    exp_v("b_rv_flag_state", 2); exp_v("b_rv_flag_rev", 0);
    cyc(P_RV); chk(32'(b_st)); chk(32'(b_rev));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/minesweeper_ctrl.md
MINESWEEPER_CTRL -- requirements
Module: minesweeper_ctrl

Interface
REQ-001 Parameter ROWS, 8, board rows (2..16).
REQ-002 Parameter COLS, 8, board columns (2..16).
REQ-003 Parameter MINES, 10, mine count (1..ROWS*COLS-1); also the flag budget.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  single-cycle pulse, begins a game.
REQ-007 mine_map  input  ROWS*COLS  mine bitmap, bit r*COLS+c = cell (r,c); sampled only on accepted start.
REQ-008 up, down, left, right  input  1 each  single-cycle move pulses.
REQ-009 reveal, flag  input  1 each  single-cycle action pulses.
REQ-010 cur_row  output  $clog2(ROWS)  cursor row; cur_col  output  $clog2(COLS)  cursor column.
REQ-011 revealed  output  ROWS*COLS  revealed bitmap; flagged  output  ROWS*COLS  flagged bitmap.
REQ-012 flags_left  output  $clog2(MINES+1)  remaining flags.
REQ-013 state_o  output  3  current state encoding; playing, game_over, win  output  1 each  decoded state flags.

Function
REQ-014 States: IDLE, LOAD, PLAY, CHECK, LOSE, WIN; one-hot decode of PLAY/LOSE/WIN drives playing/game_over/win.
REQ-015 IDLE: start -> LOAD; all other inputs ignored.
REQ-016 LOAD (one cycle): latch mine_map, clear revealed and flagged, cursor to (0,0), flags_left=MINES, revealed counter=0; -> PLAY.
REQ-017 PLAY: priority per cycle reveal > flag > up > down > left > right; only highest-priority pulse acts, others are dropped.
REQ-018 Moves wrap: up at row 0 -> ROWS-1; down at ROWS-1 -> 0; left at col 0 -> COLS-1; right at COLS-1 -> 0; update visible next cycle.
REQ-019 flag on unrevealed, unflagged cell with flags_left>0: set flag, flags_left-1; on flagged cell: clear flag, flags_left+1; on revealed cell or flags_left=0 with unflagged cell: no effect.
REQ-020 reveal on flagged or already-revealed cell: no effect, stay PLAY.
REQ-021 reveal on unrevealed, unflagged mine cell: set revealed bit, -> LOSE next cycle.
REQ-022 reveal on unrevealed, unflagged safe cell: set revealed bit, revealed counter+1, -> CHECK.
REQ-023 CHECK (one cycle, inputs ignored): counter == ROWS*COLS-MINES -> WIN, else -> PLAY.
REQ-024 LOSE: revealed forced to revealed | latched mine map on entry (mines exposed); start -> LOAD; other inputs ignored.
REQ-025 WIN: hold bitmaps; start -> LOAD; other inputs ignored.
REQ-026 start in PLAY or CHECK: ignored (no mid-game restart; restart only via rst or from LOSE/WIN).
REQ-027 Revealed counter width $clog2(ROWS*COLS+1); never wraps.

Reset
REQ-028 rst asserted: state=IDLE, cur_row=0, cur_col=0, revealed=0, flagged=0, flags_left=MINES, counter=0, latched map=0, all status outputs 0; takes effect immediately regardless of clk, including mid-game.
REQ-029 First rising edge after rst deasserts evaluates IDLE transitions normally.

Structure
REQ-030 Package minesweeper_pkg SHALL hold the state enum and its 3-bit encoding, plus a constant function for index r*COLS+c.
REQ-031 Sub-module ms_cursor SHALL implement cursor registers and wrap-around (parameters ROWS, COLS; inputs clk, rst, clear, up, down, left, right, enable).
REQ-032 Bitmaps and counters stay in minesweeper_ctrl; no memories, flip-flops only.

Verification
REQ-033 ROWS=COLS=4, MINES=1, mine at (0,0); start, reveal all 15 safe cells -> CHECK then WIN after 15th, win=1.
REQ-034 Same setup, right x1, up x1 from (0,0) -> cursor (3,1); left x2 -> (3,3).
REQ-035 Reveal at (0,0) mine -> LOSE next cycle, game_over=1, revealed bit 0 set; following start -> LOAD, PLAY, bitmaps cleared.
REQ-036 MINES=2: flag three distinct cells -> third ignored, flags_left=0; unflag one -> flags_left=1; reveal on flagged cell -> no change.
REQ-037 reveal and right pulsed same cycle -> only reveal acts, cursor unchanged; rst pulsed mid-PLAY between edges -> outputs zero immediately, state IDLE.
